mem_ctrl_icache: RTL and testbench

MEM_CTRL_ICACHE -- requirements
Module: mem_ctrl_icache

---
 rtl/mem_ctrl_icache.sv | 159 +++++++++++++++
 tb/tb_mem_ctrl_icache.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_icache.sv
// Byte-serial memory controller with a direct-mapped, one-word-per-line
// instruction cache. Fetches and data reads/writes share one byte port.
module mem_ctrl_icache #(
    parameter int ADDR_WIDTH = 17,
    parameter int LEN        = 32,
    parameter int BYTE_SIZE  = 8,
    parameter int IDX_BITS   = 4,
    parameter int DATA_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_fetch_signal,
    input  logic [ADDR_WIDTH-1:0] mem_inst_addr,
    output logic [LEN-1:0]        instruction,
    output logic                  inst_ready,
    input  logic [1:0]            data_req,
    input  logic [1:0]            data_size,
    input  logic [ADDR_WIDTH-1:0] mem_data_addr,
    input  logic [LEN-1:0]        mem_write_data,
    output logic [LEN-1:0]        mem_read_data,
    output logic                  data_ready,
    input  logic                  icache_flush,
    input  logic [BYTE_SIZE-1:0]  mem_data,
    output logic [BYTE_SIZE-1:0]  writen_data,
    output logic [ADDR_WIDTH-1:0] mem_vis_addr,
    output logic                  mem_wr,
    output logic                  busy
);
    localparam int LINES = 1 << IDX_BITS;
    localparam int TAG_W = ADDR_WIDTH - 2 - IDX_BITS;

    typedef enum logic [2:0] {IDLE, IHIT, IFILL, DREAD, DWRITE} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]          base;
    logic [2:0]                     cnt, nbytes, req_n;
    logic [3:0][BYTE_SIZE-1:0]      asm_q, wdata_q;
    logic                           inst_done, data_done;
    logic [LINES-1:0]               valid;
    logic [TAG_W-1:0]               tags  [LINES];
    logic [LEN-1:0]                 lines [LINES];

    logic [IDX_BITS-1:0]   f_idx, w0_idx, w1_idx, b_idx;
    logic [TAG_W-1:0]      f_tag, w0_tag, w1_tag, b_tag;
    logic [ADDR_WIDTH-1:0] w_end;
    logic f_hit, data_act, take_data, take_inst, rd_last, wr_last, fill_done;
    logic unused_bits;

    assign unused_bits = ^mem_inst_addr[1:0];

    assign f_idx  = mem_inst_addr[2+IDX_BITS-1:2];
    assign f_tag  = mem_inst_addr[ADDR_WIDTH-1:2+IDX_BITS];
    assign f_hit  = valid[f_idx] && (tags[f_idx] == f_tag);
    assign req_n  = (data_size == 2'b00) ? 3'd1 : (data_size == 2'b01) ? 3'd2 : 3'd4;
    assign w_end  = mem_data_addr + ADDR_WIDTH'(req_n) - ADDR_WIDTH'(1);
    assign w0_idx = mem_data_addr[2+IDX_BITS-1:2];
    assign w0_tag = mem_data_addr[ADDR_WIDTH-1:2+IDX_BITS];
    assign w1_idx = w_end[2+IDX_BITS-1:2];
    assign w1_tag = w_end[ADDR_WIDTH-1:2+IDX_BITS];
    assign b_idx  = base[2+IDX_BITS-1:2];
    assign b_tag  = base[ADDR_WIDTH-1:2+IDX_BITS];

    assign data_act  = (data_req == 2'b01) || (data_req == 2'b10);
    assign take_data = (state == IDLE) && data_act && ((DATA_FIRST != 0) || !inst_fetch_signal);
    assign take_inst = (state == IDLE) && inst_fetch_signal && !take_data;
    // Reads run one extra cycle past the last beat to capture the final byte.
    assign rd_last   = (cnt == nbytes);
    assign wr_last   = (cnt == nbytes - 3'd1);
    assign fill_done = (state == IFILL) && rd_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take_data)      state_nxt = (data_req == 2'b01) ? DREAD : DWRITE;
                else if (take_inst) state_nxt = f_hit ? IHIT : IFILL;
            end
            IHIT:         state_nxt = IDLE;
            IFILL, DREAD: if (rd_last) state_nxt = IDLE;
            DWRITE:       if (wr_last) state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_vis_addr  = '0;
        mem_wr        = 1'b0;
        writen_data   = '0;
        busy          = (state != IDLE);
        inst_ready    = (state == IHIT) || inst_done;
        data_ready    = data_done;
        instruction   = inst_ready ? asm_q : '0;
        mem_read_data = data_done ? asm_q : '0;
        if (((state == IFILL) || (state == DREAD)) && !rd_last)
            mem_vis_addr = base + ADDR_WIDTH'(cnt);
        if (state == DWRITE) begin
            mem_vis_addr = base + ADDR_WIDTH'(cnt);
            mem_wr       = 1'b1;
            writen_data  = wdata_q[cnt[1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base      <= '0;
            cnt       <= '0;
            nbytes    <= '0;
            asm_q     <= '0;
            wdata_q   <= '0;
            inst_done <= 1'b0;
            data_done <= 1'b0;
        end else begin
            inst_done <= fill_done;
            data_done <= ((state == DREAD) && rd_last) || ((state == DWRITE) && wr_last);
            if (take_data) begin
                base    <= mem_data_addr;
                nbytes  <= req_n;
                wdata_q <= mem_write_data;
                cnt     <= '0;
                asm_q   <= '0;
            end else if (take_inst) begin
                base   <= {mem_inst_addr[ADDR_WIDTH-1:2], 2'b00};
                nbytes <= 3'd4;
                cnt    <= '0;
                asm_q  <= f_hit ? lines[f_idx] : '0;
            end else if ((state == IFILL) || (state == DREAD) || (state == DWRITE)) begin
                cnt <= cnt + 3'd1;
                // Byte for beat i arrives one cycle late, so it lands at index cnt-1.
                if ((state != DWRITE) && (cnt != 3'd0))
                    asm_q[cnt[1:0] - 2'd1] <= mem_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else begin
            if (fill_done) valid[b_idx] <= 1'b1;
            if (take_data && (data_req == 2'b10)) begin
                if (tags[w0_idx] == w0_tag) valid[w0_idx] <= 1'b0;
                if (tags[w1_idx] == w1_tag) valid[w1_idx] <= 1'b0;
            end
            if (icache_flush) valid <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            lines[b_idx] <= {mem_data, asm_q[2], asm_q[1], asm_q[0]};
            tags[b_idx]  <= b_tag;
        end
    end
endmodule

// File: tb/tb_mem_ctrl_icache.sv
// Directed bench for mem_ctrl_icache: a byte memory model, a table of data
// accesses and hand-written sequences for fetch, arbitration, reset and flush.
module tb_mem_ctrl_icache;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_fetch_signal, icache_flush, mem_wr, busy, inst_ready, data_ready;
    logic [16:0] mem_inst_addr, mem_data_addr, mem_vis_addr;
    logic [31:0] instruction, mem_write_data, mem_read_data;
    logic [1:0]  data_req, data_size;
    logic [7:0]  mem_data, writen_data;

    logic        fetch2, irdy2, drdy2, wr2, busy2;
    logic [16:0] iaddr2, daddr2, vaddr2;
    logic [31:0] instr2, wdat2, rdata2;
    logic [1:0]  dreq2, dsize2;
    logic [7:0]  mem_data2, wd2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_ctrl_icache #(.DATA_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n), .inst_fetch_signal(inst_fetch_signal),
        .mem_inst_addr(mem_inst_addr), .instruction(instruction), .inst_ready(inst_ready),
        .data_req(data_req), .data_size(data_size), .mem_data_addr(mem_data_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .data_ready(data_ready),
        .icache_flush(icache_flush), .mem_data(mem_data), .writen_data(writen_data),
        .mem_vis_addr(mem_vis_addr), .mem_wr(mem_wr), .busy(busy));

    mem_ctrl_icache #(.DATA_FIRST(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .inst_fetch_signal(fetch2),
        .mem_inst_addr(iaddr2), .instruction(instr2), .inst_ready(irdy2),
        .data_req(dreq2), .data_size(dsize2), .mem_data_addr(daddr2),
        .mem_write_data(wdat2), .mem_read_data(rdata2), .data_ready(drdy2),
        .icache_flush(icache_flush), .mem_data(mem_data2), .writen_data(wd2),
        .mem_vis_addr(vaddr2), .mem_wr(wr2), .busy(busy2));

    // Memory: written bytes override a fixed pattern; 0x10..0x13 hold 13,00,00,00.
    logic [7:0] wmem  [0:131071];
    bit         wflag [0:131071];

    function automatic logic [7:0] rd(input logic [16:0] a);
        if (wflag[a]) return wmem[a];
        if (a >= 17'h10 && a <= 17'h13) return (a == 17'h10) ? 8'h13 : 8'h00;
        return a[7:0] + a[16:9] + 8'h3C;
    endfunction

    always @(posedge clk) begin
        mem_data  <= rd(mem_vis_addr);
        mem_data2 <= rd(vaddr2);
        if (mem_wr) begin
            wmem[mem_vis_addr]  <= writen_data;
            wflag[mem_vis_addr] <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Per-cycle record of the address/data bus, indexed by edge number after accept.
    logic [16:0] alog [8];
    logic [7:0]  dlog [8];

    // k = index of the edge after which the ready pulse is seen (accept edge = 0).
    task automatic do_fetch(input logic [16:0] a, input int flush_at,
                            output logic [31:0] w, output int k, output int nb);
        @(negedge clk);
        inst_fetch_signal = 1'b1;
        mem_inst_addr     = a;
        icache_flush      = (flush_at == 0);
        nb = 0; w = '0; k = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (k < 8) alog[k] = mem_vis_addr;
            if (mem_vis_addr != 0 || mem_wr) nb++;
            if (inst_ready) begin w = instruction; break; end
            k++;
            @(negedge clk);
            icache_flush = (k == flush_at);
        end
        @(negedge clk);
        inst_fetch_signal = 1'b0;
        icache_flush      = 1'b0;
    endtask

    task automatic do_data(input logic [1:0] req, input logic [1:0] sz, input logic [16:0] a,
                           input logic [31:0] wd, output logic [31:0] r, output int k);
        @(negedge clk);
        data_req = req; data_size = sz; mem_data_addr = a; mem_write_data = wd;
        r = '0; k = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (k < 8) begin alog[k] = mem_vis_addr; dlog[k] = writen_data; end
            if (data_ready) begin r = mem_read_data; break; end
            k++;
        end
        @(negedge clk);
        data_req = 2'b00;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  size;
        logic [16:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        tbl [9];
    logic [31:0] w, r;
    int          k, nb, cnt;

    initial begin
        // Expected bytes: pattern = addr[7:0] + addr[16:9] + 0x3C.
        tbl[0] = '{2'b01, 2'b00, 17'h00040, 32'h0,        32'h0000007C, 2};
        tbl[1] = '{2'b01, 2'b01, 17'h00041, 32'h0,        32'h00007E7D, 3};
        tbl[2] = '{2'b01, 2'b10, 17'h00100, 32'h0,        32'h3F3E3D3C, 5};
        tbl[3] = '{2'b01, 2'b10, 17'h000A3, 32'h0,        32'hE2E1E0DF, 5};
        tbl[4] = '{2'b10, 2'b00, 17'h00050, 32'h11223344, 32'h0,        1};
        tbl[5] = '{2'b01, 2'b00, 17'h00050, 32'h0,        32'h00000044, 2};
        tbl[6] = '{2'b10, 2'b01, 17'h00061, 32'hAABBCCDD, 32'h0,        2};
        tbl[7] = '{2'b01, 2'b10, 17'h00060, 32'h0,        32'h9FCCDD9C, 5};
        tbl[8] = '{2'b01, 2'b11, 17'h00070, 32'h0,        32'hAFAEADAC, 5};

        rst_n = 1'b0; inst_fetch_signal = 1'b0; icache_flush = 1'b0;
        mem_inst_addr = '0; data_req = '0; data_size = '0; mem_data_addr = '0; mem_write_data = '0;
        fetch2 = 1'b0; iaddr2 = '0; dreq2 = '0; dsize2 = '0; daddr2 = '0; wdat2 = '0;

        #12;
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_ready", {30'b0, inst_ready, data_ready}, 32'h0);
        chk("reset_bus", {14'b0, mem_wr, mem_vis_addr}, 32'h0);
        chk("reset_data", instruction | mem_read_data | {24'b0, writen_data}, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Cold fetch then hit.
        do_fetch(17'h00010, -1, w, k, nb);
        chk("cold_instr", w, 32'h00000013);
        chk("cold_lat", k, 5);
        chk("cold_beats", nb, 4);
        chk("cold_addrs", {alog[0][7:0], alog[1][7:0], alog[2][7:0], alog[3][7:0]}, 32'h10111213);
        do_fetch(17'h00010, -1, w, k, nb);
        chk("hit_instr", w, 32'h00000013);
        chk("hit_lat", k, 0);
        chk("hit_beats", nb, 0);

        // Misaligned word write over the cached line invalidates it.
        do_data(2'b10, 2'b10, 17'h00012, 32'hDEADBEEF, r, k);
        chk("wr_lat", k, 4);
        chk("wr_addrs", {alog[0][7:0], alog[1][7:0], alog[2][7:0], alog[3][7:0]}, 32'h12131415);
        chk("wr_bytes", {dlog[0], dlog[1], dlog[2], dlog[3]}, 32'hEFBEADDE);
        do_fetch(17'h00010, -1, w, k, nb);
        chk("postwr_lat", k, 5);
        chk("postwr_instr", w, 32'hBEEF0013);

        foreach (tbl[i]) begin
            do_data(tbl[i].req, tbl[i].size, tbl[i].addr, tbl[i].wd, r, k);
            chk($sformatf("vec%0d_data", i), r, tbl[i].exp);
            chk($sformatf("vec%0d_lat", i), k, tbl[i].lat);
        end

        // NOP encoding must not start an access.
        @(negedge clk); data_req = 2'b11; cnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (busy || mem_vis_addr != 0 || data_ready) cnt++;
        end
        @(negedge clk); data_req = 2'b00;
        chk("nop_idle", cnt, 0);

        // Tie between fetch and byte read on both arbitration polarities.
        begin
            int ki1, kd1, ki2, kd2;
            logic [31:0] vi1, vd1, vi2, vd2;
            ki1 = -1; kd1 = -1; ki2 = -1; kd2 = -1;
            vi1 = '0; vd1 = '0; vi2 = '0; vd2 = '0;
            @(negedge clk);
            inst_fetch_signal = 1'b1; mem_inst_addr = 17'h00020;
            data_req = 2'b01; data_size = 2'b00; mem_data_addr = 17'h00030;
            fetch2 = 1'b1; iaddr2 = 17'h00020;
            dreq2 = 2'b01; dsize2 = 2'b00; daddr2 = 17'h00030;
            for (int e = 0; e < 30; e++) begin
                @(posedge clk); #1;
                if (inst_ready) begin ki1 = e; vi1 = instruction; end
                if (data_ready) begin kd1 = e; vd1 = mem_read_data; end
                if (irdy2) begin ki2 = e; vi2 = instr2; end
                if (drdy2) begin kd2 = e; vd2 = rdata2; end
                @(negedge clk);
                if (ki1 >= 0) inst_fetch_signal = 1'b0;
                if (kd1 >= 0) data_req = 2'b00;
                if (ki2 >= 0) fetch2 = 1'b0;
                if (kd2 >= 0) dreq2 = 2'b00;
            end
            chk("tie_df1_data_k", kd1, 2);
            chk("tie_df1_inst_k", ki1, 8);
            chk("tie_df1_data", vd1, 32'h0000006C);
            chk("tie_df1_inst", vi1, 32'h5F5E5D5C);
            chk("tie_df0_inst_k", ki2, 5);
            chk("tie_df0_data_k", kd2, 8);
            chk("tie_df0_data", vd2, 32'h0000006C);
            chk("tie_df0_inst", vi2, 32'h5F5E5D5C);
        end

        // Half read wrapping past the top of the address space.
        do_data(2'b01, 2'b01, 17'h1FFFF, 32'h0, r, k);
        chk("wrap_data", r, 32'h00003C3A);
        chk("wrap_lat", k, 3);
        chk("wrap_addr0", alog[0], 32'h0001FFFF);
        chk("wrap_addr1", alog[1], 32'h0);

        // Reset during beat 2 of a word read.
        do_fetch(17'h00100, -1, w, k, nb);
        do_fetch(17'h00100, -1, w, k, nb);
        chk("pre_rst_hit", k, 0);
        @(negedge clk);
        data_req = 2'b01; data_size = 2'b10; mem_data_addr = 17'h00080;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_beat2_addr", mem_vis_addr, 32'h00000082);
        rst_n = 1'b0;
        #1;
        chk("rst_now_bus", {14'b0, mem_wr, mem_vis_addr}, 32'h0);
        chk("rst_now_flags", {29'b0, busy, inst_ready, data_ready}, 32'h0);
        @(negedge clk); data_req = 2'b00;
        @(negedge clk); rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin @(posedge clk); #1; if (data_ready) cnt++; end
        chk("rst_no_ready", cnt, 0);
        do_fetch(17'h00100, -1, w, k, nb);
        chk("post_rst_lat", k, 5);
        chk("post_rst_instr", w, 32'h3F3E3D3C);

        // Flush coincident with the fill-completion edge.
        do_fetch(17'h00180, 5, w, k, nb);
        chk("flush_fill_lat", k, 5);
        chk("flush_fill_instr", w, 32'hBFBEBDBC);
        do_fetch(17'h00180, -1, w, k, nb);
        chk("flush_refetch_lat", k, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
